// File: rtl/fsm_dosificador_n.sv
// ---------------------------------------------------------------------------
// fsm_dosificador_n
//
// Purpose:
//   Colour-loading sequencer for N_CH motor channels. It waits for a complete
//   set of colour readings and an operator confirm. It then drives one motor
//   at a time, starting with the highest enabled channel. Each motor runs
//   until its dosing sensor reports done. Channels disabled in the mask are
//   skipped. A per-channel timeout moves the machine to an error state, and
//   abort cancels a running sequence. With N_CH=3 and mask 3'b111 the order
//   is R(2) -> Y(1) -> B(0), as in the original 3-motor sequencer.
//
// Parameters:
//   N_CH     number of motor channels (>= 1)
//   TO_W     width of the per-channel timeout counter
//   TIMEOUT  cycles allowed per channel before error (1 .. 2**TO_W-1)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous reset, active low
//   data_full  in   colour readings complete (level)
//   enter      in   operator confirm / error acknowledge (level)
//   abort      in   cancel the loading sequence
//   ch_en      in   channel enable mask, captured when a sequence starts
//   flags      in   per-channel done flags from the dosing sensors
//   motores    out  one-hot motor drive, bit k = channel k
//   cur_ch     out  index of the active channel, 0 when not loading
//   busy       out  high while a motor is loading
//   done       out  one-cycle pulse when a sequence finishes normally
//   error      out  high while in the timeout error state
// ---------------------------------------------------------------------------
module fsm_dosificador_n #(
  parameter int N_CH    = 3,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 50000,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_full,
  input  logic              enter,
  input  logic              abort,
  input  logic [N_CH-1:0]   ch_en,
  input  logic [N_CH-1:0]   flags,
  output logic [N_CH-1:0]   motores,
  output logic [CH_W-1:0]   cur_ch,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // State encoding. Unused codes fall back to LECTURA.
  localparam logic [2:0] LECTURA = 3'd0;
  localparam logic [2:0] ESPERA  = 3'd1;
  localparam logic [2:0] CARGA   = 3'd2;
  localparam logic [2:0] FIN     = 3'd3;
  localparam logic [2:0] ERROR   = 3'd4;

  // The last counter value allowed while a channel runs without its flag.
  // The counter starts at 0 on entry, so a channel gets exactly TIMEOUT
  // cycles in CARGA before the move to ERROR.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [N_CH-1:0]  mask;
  logic [N_CH-1:0]  mask_nxt;
  logic [CH_W-1:0]  ch;
  logic [CH_W-1:0]  ch_nxt;
  logic [TO_W-1:0]  cnt;
  logic [TO_W-1:0]  cnt_nxt;

  logic [CH_W-1:0]  start_ch;
  logic [CH_W-1:0]  lower_ch;
  logic             lower_ok;

  // Find the channel that starts a sequence: the highest bit set in ch_en.
  // The loop runs upward, so the last match is the highest index. The result
  // is only used when ch_en is non-zero.
  always_comb begin
    start_ch = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_en[i]) begin
        start_ch = CH_W'(i);
      end
    end
  end

  // Find the next enabled channel below the active one in the captured mask.
  // This makes a hop from one channel to the next skip disabled channels in
  // a single step, so disabled channels get zero cycles. lower_ok is low when
  // the active channel is the last enabled channel.
  always_comb begin
    lower_ch = '0;
    lower_ok = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (mask[i] && (CH_W'(i) < ch)) begin
        lower_ch = CH_W'(i);
        lower_ok = 1'b1;
      end
    end
  end

  // Next-state logic. In CARGA, abort has priority over the active channel's
  // done flag, and the flag has priority over the timeout. A flag and a
  // timeout in the same cycle therefore finish the channel normally. Flags of
  // channels that are not active are not examined, and data_full is not used
  // once loading has started. The counter clears on every entry into CARGA,
  // including a hop from one channel to the next.
  always_comb begin
    state_nxt = state;
    mask_nxt  = mask;
    ch_nxt    = ch;
    cnt_nxt   = cnt;
    case (state)
      LECTURA: begin
        if (data_full) begin
          state_nxt = ESPERA;
        end
      end
      ESPERA: begin
        if (!data_full) begin
          state_nxt = LECTURA;
        end else if (enter) begin
          mask_nxt = ch_en;
          cnt_nxt  = '0;
          if (ch_en == '0) begin
            state_nxt = FIN;
          end else begin
            state_nxt = CARGA;
            ch_nxt    = start_ch;
          end
        end
      end
      CARGA: begin
        if (abort) begin
          state_nxt = LECTURA;
          cnt_nxt   = '0;
        end else if (flags[ch]) begin
          cnt_nxt = '0;
          if (lower_ok) begin
            state_nxt = CARGA;
            ch_nxt    = lower_ch;
          end else begin
            state_nxt = FIN;
          end
        end else if (cnt == TO_LAST) begin
          state_nxt = ERROR;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + TO_W'(1);
        end
      end
      FIN: begin
        state_nxt = LECTURA;
      end
      ERROR: begin
        if (enter || abort) begin
          state_nxt = LECTURA;
        end
      end
      default: begin
        state_nxt = LECTURA;
      end
    endcase
  end

  // State registers. An asynchronous reset clears every register at once, so
  // no state survives reset and the decoded outputs fall to zero without
  // waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LECTURA;
      mask  <= '0;
      ch    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      mask  <= mask_nxt;
      ch    <= ch_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Moore output decode. Outputs depend only on the registered state and
  // channel. The motor vector sets at most the single bit of the active
  // channel, and only while in CARGA, so it is always one-hot or zero.
  always_comb begin
    motores = '0;
    cur_ch  = '0;
    if (state == CARGA) begin
      motores[ch] = 1'b1;
      cur_ch      = ch;
    end
  end

  assign busy  = (state == CARGA);
  assign done  = (state == FIN);
  assign error = (state == ERROR);

endmodule

// File: tb/tb_fsm_dosificador_n.sv
// ---------------------------------------------------------------------------
// tb_fsm_dosificador_n
//
// Directed testbench for fsm_dosificador_n. It uses two instances:
//   dut3 : N_CH=3, TIMEOUT=8 (3-motor sequences, timeout and abort cases)
//   dut5 : N_CH=5, TIMEOUT=8 (skip order with a sparse mask)
// data_full, enter and abort are shared by both instances. The instance that
// is not being exercised is kept with an empty enable mask, so it only cycles
// through FIN and its outputs are not examined.
// ---------------------------------------------------------------------------
module tb_fsm_dosificador_n;

  logic       clk;
  logic       reset;
  logic       data_full;
  logic       enter;
  logic       abort;

  logic [2:0] ch_en3;
  logic [2:0] flags3;
  logic [2:0] mot3;
  logic [1:0] cur3;
  logic       busy3;
  logic       done3;
  logic       err3;

  logic [4:0] ch_en5;
  logic [4:0] flags5;
  logic [4:0] mot5;
  logic [2:0] cur5;
  logic       busy5;
  logic       done5;
  logic       err5;

  int checks;
  int errors;

  fsm_dosificador_n #(.N_CH(3), .TO_W(16), .TIMEOUT(8)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .data_full (data_full),
    .enter     (enter),
    .abort     (abort),
    .ch_en     (ch_en3),
    .flags     (flags3),
    .motores   (mot3),
    .cur_ch    (cur3),
    .busy      (busy3),
    .done      (done3),
    .error     (err3)
  );

  fsm_dosificador_n #(.N_CH(5), .TO_W(16), .TIMEOUT(8)) dut5 (
    .clk       (clk),
    .reset     (reset),
    .data_full (data_full),
    .enter     (enter),
    .abort     (abort),
    .ch_en     (ch_en5),
    .flags     (flags5),
    .motores   (mot5),
    .cur_ch    (cur5),
    .busy      (busy5),
    .done      (done5),
    .error     (err5)
  );

  // Clock with a 10-unit period. Inputs change and outputs are sampled on
  // the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value differs from
  // the expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Check that the selected instance is idle: no motor, no busy, no error,
  // channel index 0, and done equal to exp_done.
  task automatic checkIdle(input bit d5, input string tag, input logic exp_done);
    if (d5) begin
      checkOutput({tag, "_mot5"},  32'(mot5),  32'h0);
      checkOutput({tag, "_busy5"}, 32'(busy5), 32'h0);
      checkOutput({tag, "_done5"}, 32'(done5), 32'(exp_done));
      checkOutput({tag, "_err5"},  32'(err5),  32'h0);
      checkOutput({tag, "_cur5"},  32'(cur5),  32'h0);
    end else begin
      checkOutput({tag, "_mot3"},  32'(mot3),  32'h0);
      checkOutput({tag, "_busy3"}, 32'(busy3), 32'h0);
      checkOutput({tag, "_done3"}, 32'(done3), 32'(exp_done));
      checkOutput({tag, "_err3"},  32'(err3),  32'h0);
      checkOutput({tag, "_cur3"},  32'(cur3),  32'h0);
    end
  endtask

  // Start a sequence from LECTURA. This raises data_full with the given mask,
  // waits one cycle in ESPERA, then pulses enter. It returns on the falling
  // edge after the enter edge. data_full is dropped there, because it is
  // ignored from then on.
  task automatic applyStimulus(input bit d5, input logic [4:0] chen);
    data_full = 1'b1;
    if (d5) begin
      ch_en5 = chen;
      ch_en3 = '0;
    end else begin
      ch_en3 = chen[2:0];
      ch_en5 = '0;
    end
    @(negedge clk);
    checkIdle(d5, "espera", 1'b0);
    enter = 1'b1;
    @(negedge clk);
    enter     = 1'b0;
    data_full = 1'b0;
  endtask

  // Expect channel k to be driven for n cycles. The done flag is raised
  // during the n-th cycle and cleared after the edge that consumes it.
  task automatic runCh(input bit d5, input int k, input int n);
    for (int i = 0; i < n; i++) begin
      if (d5) begin
        checkOutput("mot5",  32'(mot5),  32'(1) << k);
        checkOutput("cur5",  32'(cur5),  32'(k));
        checkOutput("busy5", 32'(busy5), 32'h1);
      end else begin
        checkOutput("mot3",  32'(mot3),  32'(1) << k);
        checkOutput("cur3",  32'(cur3),  32'(k));
        checkOutput("busy3", 32'(busy3), 32'h1);
      end
      if (i == n - 1) begin
        if (d5) flags5 = 5'(32'(1) << k);
        else    flags3 = 3'(32'(1) << k);
      end
      @(negedge clk);
    end
    flags3 = '0;
    flags5 = '0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    data_full = 1'b0;
    enter     = 1'b0;
    abort     = 1'b0;
    ch_en3    = '0;
    flags3    = '0;
    ch_en5    = '0;
    flags5    = '0;

    // Reset state
    #1;
    checkIdle(1'b0, "rst", 1'b0);
    checkIdle(1'b1, "rst", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkIdle(1'b0, "post_rst", 1'b0);

    // Full 3-channel run: 2 -> 1 -> 0, five cycles each
    $display("[TB] full sequence 111");
    applyStimulus(1'b0, 5'b00111);
    runCh(1'b0, 2, 5);
    runCh(1'b0, 1, 5);
    runCh(1'b0, 0, 5);
    checkIdle(1'b0, "fin111", 1'b1);
    @(negedge clk);
    checkIdle(1'b0, "after111", 1'b0);

    // Mask 101: channel 1 is skipped with no cycle
    $display("[TB] mask 101");
    applyStimulus(1'b0, 5'b00101);
    runCh(1'b0, 2, 3);
    runCh(1'b0, 0, 2);
    checkIdle(1'b0, "fin101", 1'b1);
    @(negedge clk);
    checkIdle(1'b0, "after101", 1'b0);

    // Mask 000: done pulse in the cycle after enter
    $display("[TB] mask 000");
    applyStimulus(1'b0, 5'b00000);
    checkIdle(1'b0, "fin000", 1'b1);
    @(negedge clk);
    checkIdle(1'b0, "after000", 1'b0);

    // Timeout: channel 1 without its flag for 8 cycles
    $display("[TB] timeout");
    applyStimulus(1'b0, 5'b00010);
    for (int i = 0; i < 8; i++) begin
      checkOutput("to_mot3", 32'(mot3), 32'h2);
      @(negedge clk);
    end
    checkOutput("to_err3",  32'(err3),  32'h1);
    checkOutput("to_mot3z", 32'(mot3),  32'h0);
    checkOutput("to_busy3", 32'(busy3), 32'h0);
    @(negedge clk);
    checkOutput("to_hold3", 32'(err3), 32'h1);
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    checkIdle(1'b0, "to_ack", 1'b0);

    // Flag in the same cycle as the timeout: the flag wins
    $display("[TB] flag vs timeout");
    applyStimulus(1'b0, 5'b00010);
    runCh(1'b0, 1, 8);
    checkIdle(1'b0, "flag_wins", 1'b1);
    @(negedge clk);
    checkIdle(1'b0, "flag_wins_after", 1'b0);

    // Abort during CARGA(1)
    $display("[TB] abort");
    applyStimulus(1'b0, 5'b00111);
    runCh(1'b0, 2, 2);
    checkOutput("ab_mot3", 32'(mot3), 32'h2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkIdle(1'b0, "abort", 1'b0);
    @(negedge clk);
    checkIdle(1'b0, "abort_after", 1'b0);

    // data_full drops in ESPERA: back to LECTURA, so enter does nothing
    $display("[TB] data_full drop");
    data_full = 1'b1;
    ch_en3    = 3'b111;
    @(negedge clk);
    data_full = 1'b0;
    @(negedge clk);
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    checkIdle(1'b0, "df_drop", 1'b0);
    @(negedge clk);
    checkIdle(1'b0, "df_drop2", 1'b0);

    // A stray flag on channel 0 during CARGA(2) is ignored
    $display("[TB] stray flag");
    applyStimulus(1'b0, 5'b00111);
    flags3 = 3'b001;
    for (int i = 0; i < 3; i++) begin
      checkOutput("stray_mot3", 32'(mot3), 32'h4);
      @(negedge clk);
    end
    flags3 = '0;
    runCh(1'b0, 2, 2);
    runCh(1'b0, 1, 1);
    runCh(1'b0, 0, 1);
    checkIdle(1'b0, "stray_fin", 1'b1);
    @(negedge clk);

    // Reset asserted between clock edges drops the motor at once
    $display("[TB] async reset");
    applyStimulus(1'b0, 5'b00111);
    checkOutput("ar_mot3_pre", 32'(mot3), 32'h4);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("ar_mot3",  32'(mot3),  32'h0);
    checkOutput("ar_busy3", 32'(busy3), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkIdle(1'b0, "ar_after", 1'b0);

    // 5-channel run with mask 10110: order 4, 2, 1
    $display("[TB] N_CH=5 mask 10110");
    applyStimulus(1'b1, 5'b10110);
    runCh(1'b1, 4, 2);
    runCh(1'b1, 2, 3);
    runCh(1'b1, 1, 2);
    checkIdle(1'b1, "fin5", 1'b1);
    @(negedge clk);
    checkIdle(1'b1, "after5", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
